// File: rtl/friscv_pkg.sv
// Shared definitions for the Frisc-V juice dispenser control unit:
// state codes, default timing constants and a state-class helper.
package friscv_pkg;

    localparam int T_BOMBA_PAD     = 250_000_000;
    localparam int T_INTERVALO_PAD = 25_000_000;
    localparam int T_TIMEOUT_PAD   = 5_000_000;

    typedef enum logic [3:0] {
        INICIAL      = 4'h0,
        OCIOSO       = 4'h1,
        MEDE         = 4'h2,
        ESPERA       = 4'h3,
        AVALIA       = 4'h4,
        SERVE        = 4'h5,
        SERVE_MEDE   = 4'h6,
        SERVE_ESPERA = 4'h7,
        SERVE_AVALIA = 4'h8,
        FIM          = 4'h9,
        ERRO         = 4'hA
    } estado_t;

    // True in the states where the selected pump is running.
    function automatic logic em_servico(estado_t e);
        return (e == SERVE) || (e == SERVE_MEDE) ||
               (e == SERVE_ESPERA) || (e == SERVE_AVALIA);
    endfunction

endpackage

// File: rtl/friscv_uc_if.sv
// Signal bundle between the control unit and its surroundings (buttons,
// sensor datapath, pumps). The control unit is the slave side.
interface friscv_uc_if;
    // Every *_edge, fim_medida, inicia_medida, pronto and erro signal is a
    // single-cycle pulse; there is no back-pressure on any of them.
    logic       liga_frisc_edge;
    logic       liga_suco_1_edge;
    logic       liga_suco_2_edge;
    logic       fim_medida;
    logic       copo_posicionado;
    logic       inicia_medida;
    logic       ligado;
    logic       bomba_1;
    logic       bomba_2;
    logic       pronto;
    logic       erro;
    logic [3:0] db_estado;

    modport master (
        output liga_frisc_edge, liga_suco_1_edge, liga_suco_2_edge,
               fim_medida, copo_posicionado,
        input  inicia_medida, ligado, bomba_1, bomba_2, pronto, erro,
               db_estado
    );

    modport slave (
        input  liga_frisc_edge, liga_suco_1_edge, liga_suco_2_edge,
               fim_medida, copo_posicionado,
        output inicia_medida, ligado, bomba_1, bomba_2, pronto, erro,
               db_estado
    );
endinterface

// File: rtl/friscv_uc_contador.sv
// Saturating modulo counter: clears on zera, advances on conta, and holds
// at M-1, where fim is raised.
module contador_m #(
    parameter int M = 16,
    parameter int W = (M > 1) ? $clog2(M) : 1
) (
    input  logic clock,
    input  logic reset,
    input  logic zera,
    input  logic conta,
    output logic fim
);

    localparam logic [W-1:0] ULTIMO = W'(M - 1);

    logic [W-1:0] q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (zera) begin
            q <= '0;
        end else if (conta && (q != ULTIMO)) begin
            q <= q + 1'b1;
        end
    end

    assign fim = (q == ULTIMO);

endmodule

// File: rtl/friscv_uc.sv
// Frisc-V dispenser control unit: power toggle, juice request, cup check
// through the HC-SR04 datapath, timed pump run with periodic re-checks.
module friscv_uc
    import friscv_pkg::*;
#(
    parameter int T_BOMBA     = T_BOMBA_PAD,
    parameter int T_INTERVALO = T_INTERVALO_PAD,
    parameter int T_TIMEOUT   = T_TIMEOUT_PAD
) (
    input logic          clock,
    input logic          reset,
    friscv_uc_if.slave   bus
);

    estado_t estado;
    estado_t prox;
    logic    sel;
    logic    sel_prox;

    logic    inicia_medida_r;
    logic    ligado_r;
    logic    bomba_1_r;
    logic    bomba_2_r;
    logic    pronto_r;
    logic    erro_r;

    logic    fim_bomba;
    logic    fim_intervalo;
    logic    fim_timeout;

    logic    zera_bomba;
    logic    conta_bomba;
    logic    zera_intervalo;
    logic    conta_intervalo;
    logic    zera_timeout;
    logic    conta_timeout;

    // Counter controls depend on the current state only. Clearing happens in
    // the state before the one that uses the counter, so it starts at 0.
    assign zera_bomba      = (estado == AVALIA);
    assign conta_bomba     = em_servico(estado);
    assign zera_intervalo  = (estado == AVALIA) || (estado == SERVE_AVALIA);
    assign conta_intervalo = (estado == SERVE);
    assign zera_timeout    = (estado == MEDE) || (estado == SERVE_MEDE);
    assign conta_timeout   = (estado == ESPERA) || (estado == SERVE_ESPERA);

    contador_m #(.M(T_BOMBA)) u_cont_bomba (
        .clock (clock),
        .reset (reset),
        .zera  (zera_bomba),
        .conta (conta_bomba),
        .fim   (fim_bomba)
    );

    contador_m #(.M(T_INTERVALO)) u_cont_intervalo (
        .clock (clock),
        .reset (reset),
        .zera  (zera_intervalo),
        .conta (conta_intervalo),
        .fim   (fim_intervalo)
    );

    contador_m #(.M(T_TIMEOUT)) u_cont_timeout (
        .clock (clock),
        .reset (reset),
        .zera  (zera_timeout),
        .conta (conta_timeout),
        .fim   (fim_timeout)
    );

    always_comb begin
        prox     = estado;
        sel_prox = sel;
        case (estado)
            INICIAL: begin
                if (bus.liga_frisc_edge) prox = OCIOSO;
            end
            OCIOSO: begin
                if (bus.liga_frisc_edge) begin
                    prox = INICIAL;
                end else if (bus.liga_suco_1_edge) begin
                    prox     = MEDE;
                    sel_prox = 1'b0;
                end else if (bus.liga_suco_2_edge) begin
                    prox     = MEDE;
                    sel_prox = 1'b1;
                end
            end
            MEDE, ESPERA, AVALIA, SERVE, SERVE_MEDE, SERVE_ESPERA,
            SERVE_AVALIA: begin
                // Power-off beats end of pour, which beats any sensor outcome.
                if (bus.liga_frisc_edge) begin
                    prox = INICIAL;
                end else if (em_servico(estado) && fim_bomba) begin
                    prox = FIM;
                end else begin
                    case (estado)
                        MEDE:         prox = ESPERA;
                        ESPERA: begin
                            if (bus.fim_medida)  prox = AVALIA;
                            else if (fim_timeout) prox = ERRO;
                        end
                        AVALIA:       prox = bus.copo_posicionado ? SERVE : ERRO;
                        SERVE: begin
                            if (fim_intervalo) prox = SERVE_MEDE;
                        end
                        SERVE_MEDE:   prox = SERVE_ESPERA;
                        SERVE_ESPERA: begin
                            if (bus.fim_medida)  prox = SERVE_AVALIA;
                            else if (fim_timeout) prox = ERRO;
                        end
                        SERVE_AVALIA: prox = bus.copo_posicionado ? SERVE : ERRO;
                        default:      prox = estado;
                    endcase
                end
            end
            FIM:     prox = OCIOSO;
            ERRO:    prox = OCIOSO;
            default: prox = INICIAL;
        endcase
    end

    // Outputs are registered from the next state, so they line up with the
    // state register and never see an input combinationally.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado          <= INICIAL;
            sel             <= 1'b0;
            inicia_medida_r <= 1'b0;
            ligado_r        <= 1'b0;
            bomba_1_r       <= 1'b0;
            bomba_2_r       <= 1'b0;
            pronto_r        <= 1'b0;
            erro_r          <= 1'b0;
        end else begin
            estado          <= prox;
            sel             <= sel_prox;
            inicia_medida_r <= (prox == MEDE) || (prox == SERVE_MEDE);
            ligado_r        <= (prox != INICIAL);
            bomba_1_r       <= em_servico(prox) && !sel_prox;
            bomba_2_r       <= em_servico(prox) && sel_prox;
            pronto_r        <= (prox == FIM);
            erro_r          <= (prox == ERRO);
        end
    end

    assign bus.inicia_medida = inicia_medida_r;
    assign bus.ligado        = ligado_r;
    assign bus.bomba_1       = bomba_1_r;
    assign bus.bomba_2       = bomba_2_r;
    assign bus.pronto        = pronto_r;
    assign bus.erro          = erro_r;
    assign bus.db_estado     = estado;

endmodule

// File: tb/tb_friscv_uc.sv
// Directed bench for friscv_uc: a per-cycle vector table for the short
// control paths plus scripted state traces for the serving sequences.
module tb_friscv_uc;

    logic clock;
    logic reset;

    friscv_uc_if bus ();

    friscv_uc #(
        .T_BOMBA     (20),
        .T_INTERVALO (6),
        .T_TIMEOUT   (10)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic       frisc;
        logic       s1;
        logic       s2;
        logic       fim;
        logic       copo;
        logic [3:0] st;
        logic       lig;
        logic       ini;
        logic       b1;
        logic       b2;
        logic       pr;
        logic       er;
    } vec_t;

    vec_t       tbl[$];
    logic [3:0] exp_q[$];
    int         n_checks = 0;
    int         n_errors = 0;

    function automatic logic [9:0] outs();
        return {bus.db_estado, bus.ligado, bus.inicia_medida, bus.bomba_1,
                bus.bomba_2, bus.pronto, bus.erro};
    endfunction

    // Expected outputs for a given state code, straight from the state table.
    function automatic logic [9:0] exp_vec(input logic [3:0] e, input logic use2);
        logic srv;
        srv = (e >= 4'h5) && (e <= 4'h8);
        return {e, e != 4'h0, (e == 4'h2) || (e == 4'h6), srv && !use2,
                srv && use2, e == 4'h9, e == 4'hA};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        bus.liga_frisc_edge  = 1'b0;
        bus.liga_suco_1_edge = 1'b0;
        bus.liga_suco_2_edge = 1'b0;
        bus.fim_medida       = 1'b0;
    endtask

    task automatic add(input logic frisc, s1, s2, fim, copo, input logic [3:0] st,
                       input logic lig, ini, b1, b2, pr, er);
        vec_t v;
        v = '{frisc, s1, s2, fim, copo, st, lig, ini, b1, b2, pr, er};
        tbl.push_back(v);
    endtask

    task automatic push(input logic [3:0] code, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(code);
    endtask

    // Issues a request from OCIOSO and walks exp_q one cycle at a time. The
    // sensor answers dly cycles after each inicia_medida, except measurement
    // noresp_idx; measurement absent_idx reports no cup.
    task automatic run_trace(input string tag, input logic use2, input int dly,
                             input int absent_idx, input int noresp_idx,
                             output int pump);
        int since;
        int meas;
        int n;
        logic [3:0] e;
        since = -1;
        meas  = -1;
        pump  = 0;
        bus.liga_suco_1_edge = !use2;
        bus.liga_suco_2_edge = use2;
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            e = exp_q.pop_front();
            tick();
            clear_inputs();
            chk($sformatf("%s[%0d]", tag, i), 32'(outs()), 32'(exp_vec(e, use2)));
            if (use2 ? bus.bomba_2 : bus.bomba_1) pump++;
            if ((e == 4'h2) || (e == 4'h6)) begin
                meas++;
                since = 0;
            end else if (since >= 0) begin
                since++;
            end
            if ((since == dly) && (meas != noresp_idx)) begin
                bus.fim_medida       = 1'b1;
                bus.copo_posicionado = (meas != absent_idx);
                since = -1;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pump;

        reset = 1'b1;
        clear_inputs();
        bus.copo_posicionado = 1'b0;
        #1;
        chk("reset_async", 32'(outs()), 32'h0);
        tick();
        tick();
        chk("reset_held", 32'(outs()), 32'h0);
        reset = 1'b0;

        // frisc st lig ini b1 b2 pr er  (expected after the clock edge)
        add(1,0,0,0,0, 4'h1, 1,0,0,0,0,0);
        add(0,0,0,0,0, 4'h1, 1,0,0,0,0,0);
        add(0,0,1,0,0, 4'h2, 1,1,0,0,0,0);
        add(0,0,0,0,0, 4'h3, 1,0,0,0,0,0);
        add(0,0,0,0,0, 4'h3, 1,0,0,0,0,0);
        add(0,0,0,1,0, 4'h4, 1,0,0,0,0,0);
        add(0,0,0,0,0, 4'hA, 1,0,0,0,0,1);
        add(0,0,0,0,0, 4'h1, 1,0,0,0,0,0);
        add(1,0,0,0,0, 4'h0, 0,0,0,0,0,0);
        add(0,1,0,0,0, 4'h0, 0,0,0,0,0,0);
        add(1,0,0,0,0, 4'h1, 1,0,0,0,0,0);
        add(0,1,1,0,0, 4'h2, 1,1,0,0,0,0);
        add(0,0,0,0,0, 4'h3, 1,0,0,0,0,0);
        add(0,0,0,1,0, 4'h4, 1,0,0,0,0,0);
        add(0,0,0,0,1, 4'h5, 1,0,1,0,0,0);
        add(0,0,1,0,1, 4'h5, 1,0,1,0,0,0);
        add(1,0,0,0,1, 4'h0, 0,0,0,0,0,0);
        add(1,0,0,0,0, 4'h1, 1,0,0,0,0,0);
        add(0,1,0,0,0, 4'h2, 1,1,0,0,0,0);
        for (int i = 0; i < 10; i++) add(0,0,0,0,0, 4'h3, 1,0,0,0,0,0);
        add(0,0,0,0,0, 4'hA, 1,0,0,0,0,1);
        add(0,0,0,0,0, 4'h1, 1,0,0,0,0,0);

        for (int i = 0; i < tbl.size(); i++) begin
            bus.liga_frisc_edge  = tbl[i].frisc;
            bus.liga_suco_1_edge = tbl[i].s1;
            bus.liga_suco_2_edge = tbl[i].s2;
            bus.fim_medida       = tbl[i].fim;
            bus.copo_posicionado = tbl[i].copo;
            tick();
            chk($sformatf("vec[%0d]", i), 32'(outs()),
                32'({tbl[i].st, tbl[i].lig, tbl[i].ini, tbl[i].b1, tbl[i].b2,
                     tbl[i].pr, tbl[i].er}));
        end
        clear_inputs();

        // Full juice-2 serve, sensor answering 3 cycles after each start.
        push(4'h2,1); push(4'h3,3); push(4'h4,1);
        push(4'h5,6); push(4'h6,1); push(4'h7,3); push(4'h8,1);
        push(4'h5,6); push(4'h6,1); push(4'h7,2);
        push(4'h9,1); push(4'h1,1);
        run_trace("serve2", 1'b1, 3, -1, -1, pump);
        chk("serve2_pump_cycles", 32'(pump), 32'd20);

        // Juice 1, cup gone at the second re-check.
        push(4'h2,1); push(4'h3,1); push(4'h4,1);
        push(4'h5,6); push(4'h6,1); push(4'h7,1); push(4'h8,1);
        push(4'h5,6); push(4'h6,1); push(4'h7,1); push(4'h8,1);
        push(4'hA,1); push(4'h1,1);
        run_trace("no_cup", 1'b0, 1, 2, -1, pump);
        chk("no_cup_pump_cycles", 32'(pump), 32'd18);

        // Sensor silent at the first re-check: timeout while pumping.
        push(4'h2,1); push(4'h3,1); push(4'h4,1);
        push(4'h5,6); push(4'h6,1); push(4'h7,10);
        push(4'hA,1); push(4'h1,1);
        run_trace("serve_to", 1'b0, 1, -1, 1, pump);
        chk("serve_to_pump_cycles", 32'(pump), 32'd17);

        // Asynchronous reset while juice 2 is pumping.
        push(4'h2,1); push(4'h3,1); push(4'h4,1); push(4'h5,3);
        run_trace("pre_reset", 1'b1, 1, -1, -1, pump);
        chk("pre_reset_pump", 32'(bus.bomba_2), 32'd1);
        #3;
        reset = 1'b1;
        #1;
        chk("reset_mid_serve", 32'(outs()), 32'h0);
        #1;
        reset = 1'b0;
        tick();
        chk("after_reset", 32'(outs()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/friscv_uc.md
# friscv_uc

Control unit of the Frisc-V juice dispenser. Sequences the dispenser datapath:
- turns the machine on and off from the debounced `liga_frisc` edge;
- accepts a juice request from one of two button edges;
- triggers HC-SR04 measurements to confirm a cup is in place;
- runs the selected pump for a fixed time, re-checking the cup periodically;
- aborts on cup removal, sensor timeout or power-off.

It sits beside the dispenser datapath and drives its `inicia_medida` input.

## Interface

Parameters:
- `T_BOMBA`, default 250_000_000: pump-on duration in clock cycles (5 s at 50 MHz).
- `T_INTERVALO`, default 25_000_000: cycles between cup re-checks while serving.
- `T_TIMEOUT`, default 5_000_000: maximum cycles waiting for `fim_medida`.

Ports:
- `clock` in 1: system clock. Single clock domain.
- `reset` in 1: asynchronous, active-high reset.
- `liga_frisc_edge` in 1: one-cycle pulse that toggles the machine on or off.
- `liga_suco_1_edge` in 1: one-cycle request for juice 1.
- `liga_suco_2_edge` in 1: one-cycle request for juice 2.
- `fim_medida` in 1: one-cycle pulse signalling that a measurement is complete.
- `copo_posicionado` in 1: cup-present flag. Valid from the cycle after `fim_medida`.
- `inicia_medida` out 1: one-cycle measurement start pulse.
- `ligado` out 1: machine is on.
- `bomba_1` out 1: drives pump 1.
- `bomba_2` out 1: drives pump 2.
- `pronto` out 1: one-cycle pulse marking normal completion.
- `erro` out 1: one-cycle pulse marking an abort (no cup, cup removed, or timeout).
- `db_estado` out 4: current state code.

## Operation

Moore FSM. Codes are in hex.

States and transitions:
- INICIAL (0): machine off. `liga_frisc_edge` -> OCIOSO.
- OCIOSO (1): idle.
  - `liga_frisc_edge` -> INICIAL.
  - Suco edge -> MEDE. Latch `sel` (0 = suco 1, 1 = suco 2).
  - Both suco edges in the same cycle: suco 1 wins.
- MEDE (2): `inicia_medida`=1 -> ESPERA.
- ESPERA (3): clear the timeout counter on entry.
  - `fim_medida` -> AVALIA.
  - Timeout counter reaches `T_TIMEOUT`-1 -> ERRO.
- AVALIA (4): `copo_posicionado` -> SERVE, else -> ERRO.
- SERVE (5): pump on. Clear the pump and interval counters on entry from AVALIA only. Interval counter reaches `T_INTERVALO`-1 -> SERVE_MEDE.
- SERVE_MEDE (6): pump on, `inicia_medida`=1 -> SERVE_ESPERA.
- SERVE_ESPERA (7): pump on.
  - `fim_medida` -> SERVE_AVALIA.
  - Timeout -> ERRO.
- SERVE_AVALIA (8): pump on. `copo_posicionado` -> SERVE (interval counter cleared), else -> ERRO.
- FIM (9): `pronto`=1 -> OCIOSO.
- ERRO (A): `erro`=1 -> OCIOSO.

Outputs and counters:
- `bomba_1` = serve states (5..8) and `sel`=0. `bomba_2` = serve states and `sel`=1.
- `ligado` = 1 in every state except INICIAL.
- The pump counter runs in every cycle of states 5..8, including during re-measurement.

Priority in states 2..8, highest first:
1. `reset`
2. `liga_frisc_edge`: -> INICIAL, pumps off next cycle, no `pronto`/`erro`.
3. Pump counter reaches `T_BOMBA`-1 -> FIM. Any pending measurement result is discarded.
4. Timeout or cup absent -> ERRO.

Suco edges outside OCIOSO are ignored; they are not queued.

## Timing

- Reset: state INICIAL. All outputs 0, `db_estado`=0, `sel`=0, all counters 0.
- Every output is registered or decoded from state only. No input-to-output combinational path.
- Request in OCIOSO at cycle n gives MEDE at n+1, with `inicia_medida` high for exactly that cycle.
- `fim_medida` at cycle m in ESPERA gives AVALIA at m+1. The first pump cycle is m+2.
- Normal serve: each pump output is high for exactly `T_BOMBA` consecutive cycles, then FIM for 1 cycle, then OCIOSO.
- Re-check cadence: SERVE_MEDE is entered `T_INTERVALO` cycles after SERVE entry or re-entry.
- Counter widths:
  - `$clog2(T_BOMBA)`;
  - `$clog2(T_INTERVALO)`;
  - `$clog2(T_TIMEOUT)`.
- Counters saturate, never wrap. All parameters must be at least 2.

## Structure

- Package `friscv_pkg`: state enum with the codes above, and default timing constants.
- Sub-module `contador_m`: parameterised modulo counter with `zera` (clear), `conta` (enable) and `fim` (terminal count) ports. Instantiated three times (pump, interval, timeout).

## Test plan

Bench parameters: `T_BOMBA`=20, `T_INTERVALO`=6, `T_TIMEOUT`=10.

1. Reset, `liga_frisc_edge`, `liga_suco_2_edge`, `fim_medida` 3 cycles after `inicia_medida` with cup present, cup kept present -> `bomba_2` high exactly 20 cycles, `inicia_medida` re-pulsed every re-check, then one `pronto` pulse, `db_estado` back to 1.
2. Request with `copo_posicionado`=0 at AVALIA -> no pump cycle, one `erro` pulse, state OCIOSO.
3. Cup removed at the 2nd re-check -> `bomba_1` drops the cycle after SERVE_AVALIA, `erro` pulses once, no `pronto`.
4. `fim_medida` never arrives -> `erro` 10 cycles after ESPERA entry. The same check applies in SERVE_ESPERA, where the pump drops on timeout.
5. `liga_suco_1_edge` and `liga_suco_2_edge` in the same cycle -> only `bomba_1` runs. A suco edge during serving causes no change.
6. `liga_frisc_edge` mid-serve -> pumps 0 and state INICIAL next cycle. Asynchronous `reset` mid-serve -> all outputs 0 immediately.
